// File: rtl/valu_pkg.sv
// Shared vALU definitions: op codes, SEW codes, clamp kinds.
// Helpers: elem_mask (element-start byte test) and is_sub_op.
package valu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_RSUB  = 4'd2;
    localparam logic [3:0] OP_ADC   = 4'd3;
    localparam logic [3:0] OP_SBC   = 4'd4;
    localparam logic [3:0] OP_SADDU = 4'd5;
    localparam logic [3:0] OP_SADD  = 4'd6;
    localparam logic [3:0] OP_SSUBU = 4'd7;
    localparam logic [3:0] OP_SSUB  = 4'd8;
    localparam logic [3:0] OP_MADC  = 4'd9;
    localparam logic [3:0] OP_MSBC  = 4'd10;

    localparam logic [1:0] SEW_E8  = 2'd0;
    localparam logic [1:0] SEW_E16 = 2'd1;
    localparam logic [1:0] SEW_E32 = 2'd2;
    localparam logic [1:0] SEW_E64 = 2'd3;

    localparam logic [1:0] CLAMP_ONES = 2'd0;
    localparam logic [1:0] CLAMP_ZERO = 2'd1;
    localparam logic [1:0] CLAMP_MAX  = 2'd2;
    localparam logic [1:0] CLAMP_MIN  = 2'd3;

    // True when byte i is the least significant byte of an element.
    function automatic logic elem_mask(input logic [1:0] sew, input int i);
        logic r;
        r = 1'b1;
        case (sew)
            SEW_E8:  r = 1'b1;
            SEW_E16: r = (i[0] == 1'b0);
            SEW_E32: r = (i[1:0] == 2'b00);
            SEW_E64: r = (i[2:0] == 3'b000);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Ops computed as a + ~b + cin; their carry_out reports borrow.
    function automatic logic is_sub_op(input logic [3:0] op);
        return (op == OP_SUB)   || (op == OP_RSUB) ||
               (op == OP_SBC)   || (op == OP_SSUBU) ||
               (op == OP_SSUB)  || (op == OP_MSBC);
    endfunction

endpackage

// File: rtl/vadd_byte_lane.sv
// One byte lane: 9-bit sums of a+b with carry-in 0 and 1.
// Ports: a, b (bytes) -> sum0 (cin=0), sum1 (cin=1); bit 8 is carry.
module vadd_byte_lane (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] sum0,
    output logic [8:0] sum1
);

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + 9'd1;

endmodule

// File: rtl/vadd_sat_pipe.sv
// 2-stage SIMD add/sub with saturation and carry/borrow-out masks.
// Ports: in_valid/in_ready + vec0, vec1, carry_in, sew, op_sel, tag_in;
//        out_valid/out_ready + result, carry_out, sat, tag_out.
module vadd_sat_pipe
    import valu_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int SEW_WIDTH   = 2,
    parameter int OPSEL_WIDTH = 4,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  vec0,
    input  logic [DATA_WIDTH-1:0]  vec1,
    input  logic [DATA_WIDTH/8-1:0] carry_in,
    input  logic [SEW_WIDTH-1:0]   sew,
    input  logic [OPSEL_WIDTH-1:0] op_sel,
    input  logic [TAG_WIDTH-1:0]   tag_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [DATA_WIDTH/8-1:0] carry_out,
    output logic                   sat,
    output logic [TAG_WIDTH-1:0]   tag_out
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(NB);

    // ---------------- stage 1: operand prep + byte sums
    logic [OPSEL_WIDTH-1:0] op_n;
    logic [DATA_WIDTH-1:0]  opa;
    logic [DATA_WIDTH-1:0]  opb;
    logic [NB-1:0][8:0]     lane_s0;
    logic [NB-1:0][8:0]     lane_s1;
    logic [NB-1:0]          xs;
    logic [NB-1:0]          ys;

    always_comb begin
        op_n = op_sel;
        if (op_sel > OP_MSBC)
            op_n = OP_ADD;
        // RSUB is b - a: swap so the lanes always do x + ~y + cin.
        if (op_n == OP_RSUB) begin
            opa = vec1;
            opb = vec0;
        end else begin
            opa = vec0;
            opb = vec1;
        end
        if (is_sub_op(op_n))
            opb = ~opb;
        for (int j = 0; j < NB; j++) begin
            xs[j] = opa[8*j+7];
            ys[j] = opb[8*j+7];
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_lane
        vadd_byte_lane u_lane (
            .a    (opa[8*g +: 8]),
            .b    (opb[8*g +: 8]),
            .sum0 (lane_s0[g]),
            .sum1 (lane_s1[g])
        );
    end

    logic                   s1_valid;
    logic [NB-1:0][8:0]     s1_sum0;
    logic [NB-1:0][8:0]     s1_sum1;
    logic [NB-1:0]          s1_xs;
    logic [NB-1:0]          s1_ys;
    logic [SEW_WIDTH-1:0]   s1_sew;
    logic [OPSEL_WIDTH-1:0] s1_op;
    logic [NB-1:0]          s1_carry;
    logic [TAG_WIDTH-1:0]   s1_tag;
    logic                   s2_advance;

    assign s2_advance = !out_valid | out_ready;
    assign in_ready   = !s1_valid | s2_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_xs    <= '0;
            s1_ys    <= '0;
            s1_sew   <= '0;
            s1_op    <= '0;
            s1_carry <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum0  <= lane_s0;
                s1_sum1  <= lane_s1;
                s1_xs    <= xs;
                s1_ys    <= ys;
                s1_sew   <= sew;
                s1_op    <= op_n;
                s1_carry <= carry_in;
                s1_tag   <= tag_in;
            end
        end
    end

    // ---------------- stage 2: carry select, saturation, pack
    logic [DATA_WIDTH-1:0] res_c;
    logic [NB-1:0]         co_c;
    logic [NB-1:0]         clamp_en;
    logic [NB-1:0][1:0]    clamp_kind;
    logic                  s1_sub;

    assign s1_sub = is_sub_op(s1_op);

    always_comb begin
        logic          c;
        logic [8:0]    b9;
        logic [IW-1:0] e;
        logic          last;
        logic          ovf;
        c          = 1'b0;
        b9         = '0;
        e          = '0;
        last       = 1'b0;
        ovf        = 1'b0;
        res_c      = '0;
        co_c       = '0;
        clamp_en   = '0;
        clamp_kind = '0;
        for (int j = 0; j < NB; j++) begin
            e    = IW'(j) >> s1_sew;
            last = (j == NB - 1) || elem_mask(s1_sew, j + 1);
            // Element start: restart the chain from the op's carry-in.
            if (elem_mask(s1_sew, j)) begin
                if (s1_op == OP_ADC || s1_op == OP_MADC)
                    c = s1_carry[e];
                else if (s1_op == OP_SBC || s1_op == OP_MSBC)
                    c = ~s1_carry[e];
                else
                    c = s1_sub;
            end
            b9 = c ? s1_sum1[j] : s1_sum0[j];
            res_c[8*j +: 8] = b9[7:0];
            c = b9[8];
            if (last) begin
                co_c[e] = s1_sub ? ~c : c;
                ovf = (s1_xs[j] == s1_ys[j]) && (b9[7] != s1_xs[j]);
                unique case (1'b1)
                    (s1_op == OP_SADDU): begin
                        clamp_en[e]   = c;
                        clamp_kind[e] = CLAMP_ONES;
                    end
                    (s1_op == OP_SSUBU): begin
                        clamp_en[e]   = ~c;
                        clamp_kind[e] = CLAMP_ZERO;
                    end
                    (s1_op == OP_SADD || s1_op == OP_SSUB): begin
                        clamp_en[e]   = ovf;
                        clamp_kind[e] = s1_xs[j] ? CLAMP_MIN : CLAMP_MAX;
                    end
                    default: ;
                endcase
            end
        end
        for (int j = 0; j < NB; j++) begin
            e    = IW'(j) >> s1_sew;
            last = (j == NB - 1) || elem_mask(s1_sew, j + 1);
            if (clamp_en[e]) begin
                unique case (clamp_kind[e])
                    CLAMP_ONES: res_c[8*j +: 8] = 8'hFF;
                    CLAMP_ZERO: res_c[8*j +: 8] = 8'h00;
                    CLAMP_MAX:  res_c[8*j +: 8] = last ? 8'h7F : 8'hFF;
                    CLAMP_MIN:  res_c[8*j +: 8] = last ? 8'h80 : 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= '0;
            sat       <= 1'b0;
            tag_out   <= '0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result    <= res_c;
                carry_out <= co_c;
                sat       <= |clamp_en;
                tag_out   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_vadd_sat_pipe.sv
// Directed bench for vadd_sat_pipe: per-op vectors, streaming
// with backpressure, and reset with ops in flight.
module tb_vadd_sat_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] vec0 = '0;
    logic [63:0] vec1 = '0;
    logic [7:0]  carry_in = '0;
    logic [1:0]  sew = '0;
    logic [3:0]  op_sel = '0;
    logic [3:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic [7:0]  carry_out;
    logic        sat;
    logic [3:0]  tag_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vadd_sat_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vec0      (vec0),
        .vec1      (vec1),
        .carry_in  (carry_in),
        .sew       (sew),
        .op_sel    (op_sel),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .sat       (sat),
        .tag_out   (tag_out)
    );

    task automatic check(input string nm, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [63:0] v0,
                          input logic [63:0] v1, input logic [7:0] ci,
                          input logic [1:0] sw, input logic [3:0] op,
                          input logic [3:0] tg, input logic [63:0] er,
                          input logic [7:0] eco, input logic es);
        int n;
        @(negedge clk);
        vec0 = v0; vec1 = v1; carry_in = ci;
        sew = sw; op_sel = op; tag_in = tg;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_valid"}, {63'b0, out_valid}, 64'd1);
        check({nm, "_lat"}, 64'(n), 64'd2);
        check({nm, "_res"}, result, er);
        check({nm, "_co"}, {56'b0, carry_out}, {56'b0, eco});
        check({nm, "_sat"}, {63'b0, sat}, {63'b0, es});
        check({nm, "_tag"}, {60'b0, tag_out}, {60'b0, tg});
    endtask

    logic [63:0] exp_res [8];
    int sent, recv, cyc;
    bit dropped;
    int inflight_at_drop;
    int stray;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_result", result, 64'd0);
        check("rst_co", {56'b0, carry_out}, 64'd0);
        check("rst_sat", {63'b0, sat}, 64'd0);
        check("rst_tag", {60'b0, tag_out}, 64'd0);

        // op codes: ADD0 SUB1 RSUB2 ADC3 SBC4 SADDU5 SADD6 SSUBU7 SSUB8 MADC9 MSBC10
        run_op("e8_add", 64'h0000_0000_0000_FF7F, 64'h0000_0000_0000_0101,
               8'h00, 2'd0, 4'd0, 4'h1, 64'h0000_0000_0000_0080, 8'h02, 1'b0);
        run_op("e16_sadd", 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001,
               8'h00, 2'd1, 4'd6, 4'h2, 64'h0000_0000_0000_7FFF, 8'h00, 1'b1);
        run_op("e16_ssubu", 64'h0, 64'h0000_0000_0000_0001,
               8'h00, 2'd1, 4'd7, 4'h3, 64'h0, 8'h01, 1'b1);
        run_op("e64_sbc", 64'h0, 64'h0, 8'h01, 2'd3, 4'd4, 4'h4,
               64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1'b0);
        run_op("e32_madc", 64'h0000_0000_FFFF_FFFF, 64'h0, 8'h01, 2'd2,
               4'd9, 4'h5, 64'h0, 8'h01, 1'b0);
        run_op("e8_rsub", 64'h05, 64'h03, 8'h00, 2'd0, 4'd2, 4'h6,
               64'h0000_0000_0000_00FE, 8'h01, 1'b0);
        run_op("e8_saddu", 64'h10F0, 64'h2020, 8'h00, 2'd0, 4'd5, 4'h7,
               64'h0000_0000_0000_30FF, 8'h01, 1'b1);
        run_op("e32_ssub", 64'h0000_0000_8000_0000, 64'h1, 8'h00, 2'd2,
               4'd8, 4'h8, 64'h0000_0000_8000_0000, 8'h00, 1'b1);
        run_op("op12_add", 64'h01, 64'h02, 8'h00, 2'd0, 4'd12, 4'h9,
               64'h03, 8'h00, 1'b0);

        // Stream 8 e8 ADDs; out_ready low for cycles 3..6.
        for (int i = 0; i < 8; i++)
            exp_res[i] = {8{8'(i + 8'h11)}};
        sent = 0; recv = 0; dropped = 1'b0; inflight_at_drop = -1;
        cyc = 0;
        while ((sent < 8 || recv < 8) && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            vec0      = {8{8'(sent)}};
            vec1      = {8{8'h11}};
            sew = 2'd0; op_sel = 4'd0; carry_in = 8'h00;
            tag_in    = 4'(sent);
            #1;
            if (in_valid && !in_ready && !dropped) begin
                dropped = 1'b1;
                inflight_at_drop = sent - recv;
            end
            if (out_valid && recv < 8) begin
                check("strm_res", result, exp_res[recv]);
                check("strm_tag", {60'b0, tag_out}, 64'(recv));
                if (out_ready)
                    recv++;
            end
            if (in_valid && in_ready)
                sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("strm_recv", 64'(recv), 64'd8);
        check("strm_drop", {63'b0, dropped}, 64'd1);
        check("strm_inflight", 64'(inflight_at_drop), 64'd2);
        repeat (3) @(negedge clk);
        check("strm_no_dup", {63'b0, out_valid}, 64'd0);

        // Reset with two ops held in the pipe.
        out_ready = 1'b0;
        vec0 = 64'h1; vec1 = 64'h1; op_sel = 4'd0; tag_in = 4'hA;
        in_valid = 1'b1;
        @(negedge clk);
        tag_in = 4'hB;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_ready", {63'b0, in_ready}, 64'd1);
        check("midrst_result", result, 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid)
                stray++;
        end
        check("midrst_stray", 64'(stray), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
